// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator for a single-port synchronous data memory. Accepts one
//   byte-addressed request at a time, turns it into word-addressed memory
//   cycles (read-modify-write for byte/halfword stores) and returns ARMv4
//   formatted load data (byte/half extraction with sign/zero extension, rotated
//   unaligned word loads).
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   req_valid       request strobe; accepted when req_ready is high
//   req_ready       high only while idle
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 halfword, 1x word
//   req_signed      sign-extend byte/half loads
//   req_addr        byte address (ADDR_W+2 bits)
//   req_wdata       right-aligned store data
//   rsp_valid       one-cycle completion pulse for every request
//   rsp_rdata       formatted load result, held until the next load completes
//   mem_address     word address to memory
//   mem_data_in     write data to memory
//   mem_write       memory write enable
//   mem_data_out    registered read data from memory

module mem_access_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        accept;

  assign accept = (state == IDLE) && req_valid;

  // Extract and extend load data from the word read back in CAP.
  // Size 11 behaves as a word access.
  function automatic logic [31:0] load_format(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [31:0] result;
    logic [7:0]  b;
    logic [15:0] h;
    b = word[7:0];
    unique case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    unique case (size)
      2'b00: result = {{24{sgn & b[7]}}, b};
      2'b01: result = {{16{sgn & h[15]}}, h};
      default: begin
        // Unaligned word loads rotate right by 8 * lane.
        unique case (lane)
          2'd0: result = word;
          2'd1: result = {word[7:0],  word[31:8]};
          2'd2: result = {word[15:0], word[31:16]};
          2'd3: result = {word[23:0], word[31:24]};
          default: result = word;
        endcase
      end
    endcase
    return result;
  endfunction

  // Merge store data into the word read back in CAP; untouched lanes keep
  // their old contents.
  function automatic logic [31:0] store_merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] result;
    unique case (size)
      2'b00: begin
        unique case (lane)
          2'd0: result = {old[31:8],  wdata[7:0]};
          2'd1: result = {old[31:16], wdata[7:0], old[7:0]};
          2'd2: result = {old[31:24], wdata[7:0], old[15:0]};
          2'd3: result = {wdata[7:0], old[23:0]};
          default: result = old;
        endcase
      end
      2'b01: result = lane[1] ? {wdata[15:0], old[15:0]} : {old[31:16], wdata[15:0]};
      default: result = wdata;
    endcase
    return result;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs. mem_write comes straight from the
  // state register so an asynchronous reset removes it immediately.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_write  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (req_write && req_size[1]) ? WR : RD;
        end
      end
      RD:   state_next = CAP;
      CAP:  state_next = write_q ? WR : RESP;
      WR: begin
        mem_write  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and datapath. Word stores load mem_data_in at accept time
  // and skip the read; partial stores fill it with the merged word in CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 32'h0;
      mem_address <= '0;
      mem_data_in <= 32'h0;
      rsp_rdata   <= 32'h0;
    end else begin
      if (accept) begin
        lane_q      <= req_addr[1:0];
        size_q      <= req_size;
        sign_q      <= req_signed;
        write_q     <= req_write;
        wdata_q     <= req_wdata;
        mem_address <= req_addr[ADDR_W+1:2];
        if (req_write && req_size[1]) begin
          mem_data_in <= req_wdata;
        end
      end
      if (state == CAP) begin
        if (write_q) begin
          mem_data_in <= store_merge(mem_data_out, wdata_q, size_q, lane_q);
        end else begin
          rsp_rdata <= load_format(mem_data_out, size_q, lane_q, sign_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a 512x32 registered-read memory
//   model. Stimulus pushes expected responses into a scoreboard queue; an
//   independent monitor pops and compares whenever rsp_valid is seen.

module tb_mem_access_unit;

  localparam int ADDR_W = 9;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_write;
  logic [31:0]       mem_data_out;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with a backdoor poke port so the bench can preload words.
  logic [31:0] mem [0:511];
  logic        poke_en;
  logic [8:0]  poke_addr;
  logic [31:0] poke_data;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_write) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks       = 0;
  int failures     = 0;
  int last_rsp_cyc = -100;
  int prev_rsp_cyc = -100;
  int rsp_count    = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      prev_rsp_cyc = last_rsp_cyc;
      last_rsp_cyc = cyc;
      rsp_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_latency", cyc - mon_e.start, mon_e.lat);
        if (mon_e.is_load) checkOutput("rsp_rdata", rsp_rdata, mon_e.data);
      end
    end
  end

  task automatic poke(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    if (!req_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request and observe the memory port until its response.
  // exp_word is the load result for loads, or the resulting memory word for stores.
  task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [10:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_word);
    int          lat;
    int          wcnt = 0;
    logic        done = 1'b0;
    logic        first_wr = 1'b0;
    logic [8:0]  waddr_seen = '0;
    logic [31:0] wdata_seen = '0;
    lat = !wr ? 3 : (sz[1] ? 2 : 4);
    waitReady();
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    sb.push_back('{is_load: !wr, data: exp_word, start: cyc, lat: lat});
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 1'b0;
        checkOutput("mem_address", {23'd0, mem_address}, {23'd0, addr[10:2]});
        checkOutput("ready_busy", {31'd0, req_ready}, 32'd0);
        first_wr = mem_write;
      end
      if (mem_write) begin
        wcnt++;
        waddr_seen = mem_address;
        wdata_seen = mem_data_in;
      end
      if (rsp_valid) done = 1'b1;
    end
    if (!done) checkOutput("rsp_timeout", 32'd0, 32'd1);
    checkOutput("mem_write_cycles", wcnt, wr ? 32'd1 : 32'd0);
    if (wr) begin
      checkOutput("wr_address", {23'd0, waddr_seen}, {23'd0, addr[10:2]});
      checkOutput("wr_data", wdata_seen, exp_word);
      checkOutput("mem_word", mem[addr[10:2]], exp_word);
      checkOutput("first_cycle_write", {31'd0, first_wr}, sz[1] ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int busy;
    int s1;
    int base;
    int n;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("reset_mem_address", {23'd0, mem_address}, 32'd0);
    checkOutput("reset_mem_data_in", mem_data_in, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    poke(9'd5, 32'h01234567);

    // Word store, then aligned and rotated word loads.
    applyStimulus(1'b1, 2'b10, 1'b0, 11'h010, 32'hDEADBEEF, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 11'h011, 32'h0, 32'hEFDEADBE);
    applyStimulus(1'b0, 2'b11, 1'b1, 11'h013, 32'h0, 32'hADBEEFDE);

    // Byte store, then byte/half loads with and without sign extension.
    applyStimulus(1'b1, 2'b00, 1'b1, 11'h012, 32'h123456A5, 32'hDEA5BEEF);
    applyStimulus(1'b0, 2'b00, 1'b1, 11'h012, 32'h0, 32'hFFFFFFA5);
    applyStimulus(1'b0, 2'b00, 1'b0, 11'h012, 32'h0, 32'h000000A5);
    applyStimulus(1'b0, 2'b01, 1'b1, 11'h012, 32'h0, 32'hFFFFDEA5);
    applyStimulus(1'b0, 2'b01, 1'b0, 11'h013, 32'h0, 32'h0000DEA5);
    applyStimulus(1'b0, 2'b00, 1'b1, 11'h010, 32'h0, 32'hFFFFFFEF);

    // Half store; rsp_rdata must keep the last load result across stores.
    applyStimulus(1'b1, 2'b01, 1'b0, 11'h010, 32'h00001111, 32'hDEA51111);
    checkOutput("rdata_held", rsp_rdata, 32'hFFFFFFEF);

    // Top word of the address space.
    applyStimulus(1'b1, 2'b10, 1'b0, 11'h7FC, 32'hCAFEF00D, 32'hCAFEF00D);
    applyStimulus(1'b0, 2'b01, 1'b0, 11'h7FE, 32'h0, 32'h0000CAFE);
    applyStimulus(1'b0, 2'b01, 1'b1, 11'h7FC, 32'h0, 32'hFFFFF00D);

    // Reset during the WR cycle of a byte store.
    poke(9'd4, 32'hDEADBEEF);
    waitReady();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 11'h010; req_wdata = 32'h00000055;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_test_in_wr", {31'd0, mem_write}, 32'd1);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mem_write_drop", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_ready_async", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mem_unchanged", mem[4], 32'hDEADBEEF);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("rst_no_rsp", seen, 32'd0);
    checkOutput("rst_ready_after", {31'd0, req_ready}, 32'd1);

    // Back-to-back word loads with req_valid held high.
    waitReady();
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 11'h010; req_wdata = '0;
    sb.push_back('{is_load: 1'b1, data: 32'hDEADBEEF, start: cyc, lat: 3});
    s1 = cyc;
    base = rsp_count;
    busy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_addr = 11'h014;
      if (req_ready) break;
      busy++;
    end
    checkOutput("b2b_busy_cycles", busy, 32'd3);
    checkOutput("b2b_accept_gap", cyc - s1, 32'd4);
    checkOutput("b2b_accept_after_rsp", cyc - last_rsp_cyc, 32'd1);
    sb.push_back('{is_load: 1'b1, data: 32'h01234567, start: cyc, lat: 3});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rsp_count < base + 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_rsp_count", rsp_count - base, 32'd2);
    checkOutput("b2b_rsp_spacing", last_rsp_cyc - prev_rsp_cyc, 32'd4);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator/master for the single-port synchronous data memory (sync_memory). It accepts one load/store request at a time from the processor's load/store stage using a byte address. It converts each request into word-addressed memory read/write cycles, including read-modify-write for byte and halfword stores. It returns ARMv4-formatted load data: byte/half extraction, sign/zero extension, and rotated unaligned word loads.

Parameters:
ADDR_W, 9, word-address width of the memory port; byte address is ADDR_W+2 bits.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request strobe from load/store stage
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
req_signed  in  1  loads only: 1 = sign-extend byte/half
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle completion pulse, for loads and stores
rsp_rdata  out  32  load result; valid only when rsp_valid=1 for a load
mem_address  out  ADDR_W  word address to memory
mem_data_in  out  32  write data to memory
mem_write  out  1  memory write enable
mem_data_out  in  32  registered read data from memory; valid the cycle after the address was presented with mem_write=0

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rsp_valid=0, rsp_rdata=0, mem_address=0, mem_data_in=0, mem_write=0.
- mem_write must decode from the state register only, so it drops the instant rst_n falls.
- States: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
- Acceptance: a request is accepted at a posedge with state=IDLE and req_valid=1.
  - Latch the word address (req_addr[ADDR_W+1:2]), lane bits (req_addr[1:0]), size, signed, write and wdata.
  - mem_address drives the latched word address from the next cycle onward.
  - Inputs are ignored outside IDLE.
- Next state after acceptance:
  - Word store goes to WR, with mem_data_in=req_wdata.
  - All loads and byte/half stores go to RD.
- RD: mem_write=0 and address presented. Next state is CAP.
- CAP: mem_data_out is valid.
  - Load: compute the result (below), register it into rsp_rdata, go to RESP.
  - Byte/half store: register the merged word into mem_data_in, go to WR.
- WR: mem_write=1 for exactly this cycle; the memory writes at the ending posedge. Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response. rsp_rdata holds its value until the next load completes.
- Latency from the accept edge to rsp_valid high:
  - word store: 2 cycles
  - byte/half store: 4 cycles
  - load: 3 cycles
  - Minimum spacing between accepts is the latency + 1, because IDLE lasts at least one cycle.
- Load formatting (little-endian; lane = addr[1:0]):
  - Byte: bits [8*lane+7:8*lane], zero- or sign-extended per req_signed.
  - Half: lane addr[1] selects [15:0] or [31:16]; addr[0] is ignored; zero- or sign-extended.
  - Word: rotate right by 8*addr[1:0]. Aligned loads return the word unchanged.
- Store merge:
  - Byte replaces lane addr[1:0] with wdata[7:0].
  - Half replaces the half selected by addr[1] with wdata[15:0]; addr[0] is ignored.
  - Word stores ignore addr[1:0] and write wdata unmodified.
  - Unmodified lanes keep the value read in CAP.
- req_signed is ignored for stores and word loads.
- Reset mid-operation: the transaction is abandoned and no rsp_valid is produced. If reset hits during WR, no memory write may occur at the following edge.
- Address wrap: none. The full byte address maps directly; the top word is 2^ADDR_W-1.

Test Plan:
- Bench memory model: 512x32 with a registered read.
- Word store addr 0x010, wdata 0xDEADBEEF -> mem_write high exactly 1 cycle with mem_address 0x004, mem_data_in 0xDEADBEEF; rsp_valid 2 cycles after accept; mem[4]=0xDEADBEEF.
- Word load 0x010 -> rsp_rdata 0xDEADBEEF 3 cycles after accept; word load 0x011 -> 0xEFDEADBE; word load 0x013 -> 0xADBEEFDE.
- Byte store 0x012, wdata 0x123456A5, mem[4]=0xDEADBEEF -> RD then WR seen on the port, mem[4]=0xDEA5BEEF, rsp_valid 4 cycles after accept. Half store 0x010, wdata 0x00001111 -> mem[4]=0xDEA51111.
- With mem[4]=0xDEA5BEEF:
  - signed byte load 0x012 -> 0xFFFFFFA5
  - unsigned byte load 0x012 -> 0x000000A5
  - signed half load 0x012 -> 0xFFFFDEA5
  - unsigned half load 0x013 -> 0x0000DEA5
  - signed byte load 0x010 -> 0xFFFFFFEF
- Reset during WR of byte store 0x010 (mem[4]=0xDEADBEEF) -> mem_write falls combinationally with rst_n, mem[4] unchanged, no rsp_valid, req_ready=1 after release.
- req_valid held high with two word loads (0x010, 0x014) -> req_ready low in all non-IDLE cycles; second accepted exactly 1 cycle after the first rsp_valid; two rsp_valid pulses 4 cycles apart.
